// File: rtl/zx8x_pkg.sv
// Shared types and constants for the ZX80/ZX81 instant tape loader.
// Holds the loader state encoding, ROM trap windows and the patch loop template.
package zx8x_pkg;

  typedef enum logic [2:0] {
    ST_EMPTY   = 3'd0,
    ST_LOADING = 3'd1,
    ST_READY   = 3'd2,
    ST_COPY    = 3'd3,
    ST_DONE    = 3'd4
  } zx8x_state_e;

  localparam logic [15:0] TRAP_ZX81 = 16'h0347;
  localparam logic [15:0] TRAP_ZX80 = 16'h0207;
  localparam logic [15:0] END_ZX81  = 16'h03C3;
  localparam logic [15:0] END_ZX80  = 16'h024D;

  localparam logic [7:0] LOOP_LO_ZX81 = 8'h07;
  localparam logic [7:0] LOOP_LO_ZX80 = 8'h03;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_SCF = 8'h37;

  // Slots 1 and 5 are placeholders filled per state/model by patch_byte.
  localparam logic [0:7][7:0] PATCH_TPL = {
    8'hAF, 8'h00, 8'h30, 8'hFD, 8'hC3, 8'h00, 8'h02, 8'hFF
  };

  function automatic logic [7:0] patch_byte(input logic [15:0] idx,
                                            input logic        done,
                                            input logic        zx81);
    logic [7:0] b;
    b = 8'hFF;
    if (idx < 16'd7) begin
      case (idx[2:0])
        3'd1:    b = done ? OP_SCF : OP_NOP;
        3'd5:    b = zx81 ? LOOP_LO_ZX81 : LOOP_LO_ZX80;
        default: b = PATCH_TPL[idx[2:0]];
      endcase
    end else begin
      b = 8'hFF;
    end
    return b;
  endfunction

endpackage

// File: rtl/zx8x_tape_buf.sv
// Private image buffer: write port from the download channel, registered read port.
// Contents survive reset on purpose so a loaded image is only replaced by a new download.
module zx8x_tape_buf
  import zx8x_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [0:(1<<AW)-1];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/zx8x_fastload.sv
// Instant tape loader: captures a .o/.p image, then on a LOAD trap overlays a short
// patch loop on the opcode stream and copies the image into RAM one byte per CPU ce.
module zx8x_fastload
  import zx8x_pkg::*;
#(
  parameter int          TAPE_AW = 14,
  parameter logic [15:0] O_BASE  = 16'h4000,
  parameter logic [15:0] P_BASE  = 16'h4009
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               ce_cpu_p,
  input  logic               zx81,
  input  logic               ioctl_download,
  input  logic [7:0]         ioctl_index,
  input  logic               ioctl_wr,
  input  logic [24:0]        ioctl_addr,
  input  logic [7:0]         ioctl_dout,
  input  logic [15:0]        cpu_addr,
  input  logic               nM1,
  output logic               active,
  output logic [7:0]         patch_dout,
  output logic               ram_we,
  output logic [15:0]        ram_addr,
  output logic [7:0]         ram_data,
  output logic               tape_ready,
  output logic               overflow,
  output logic [TAPE_AW:0]   tape_len
);

  zx8x_state_e      state_q;
  logic             dl_q;
  logic             m1_q;
  logic             is_p_q;
  logic             tape_ready_q;
  logic             overflow_q;
  logic             active_q;
  logic             ram_we_q;
  logic [15:0]      ram_addr_q;
  logic [7:0]       ram_data_q;
  logic [TAPE_AW:0] tape_len_q;
  logic [TAPE_AW:0] rd_ptr_q;

  logic             dl_start_s;
  logic             dl_end_s;
  logic             m1_fall_s;
  logic             in_range_s;
  logic             buf_we_s;
  logic [15:0]      trap_addr_s;
  logic [15:0]      end_addr_s;
  logic [15:0]      base_s;
  logic             trap_hit_s;
  logic             exit_hit_s;
  logic [7:0]       rd_data_s;

  assign dl_start_s  = ioctl_download & ~dl_q & (ioctl_index != 8'h00);
  assign dl_end_s    = ~ioctl_download & dl_q;
  assign m1_fall_s   = m1_q & ~nM1;
  assign in_range_s  = (ioctl_addr >> TAPE_AW) == 25'd0;
  assign buf_we_s    = (state_q == ST_LOADING) & ioctl_wr & in_range_s;
  assign trap_addr_s = zx81 ? TRAP_ZX81 : TRAP_ZX80;
  assign end_addr_s  = zx81 ? END_ZX81 : END_ZX80;
  assign base_s      = is_p_q ? P_BASE : O_BASE;

  assign trap_hit_s = m1_fall_s & tape_ready_q & (cpu_addr == trap_addr_s) &
                      ((state_q == ST_READY) | (state_q == ST_DONE));
  assign exit_hit_s = m1_fall_s & tape_ready_q &
                      ((cpu_addr >= end_addr_s) | (cpu_addr < trap_addr_s)) &
                      ((state_q == ST_COPY) | (state_q == ST_DONE));

  zx8x_tape_buf #(
    .AW (TAPE_AW)
  ) u_buf (
    .clk_i   (clk_sys),
    .we_i    (buf_we_s),
    .waddr_i (ioctl_addr[TAPE_AW-1:0]),
    .wdata_i (ioctl_dout),
    .raddr_i (rd_ptr_q[TAPE_AW-1:0]),
    .rdata_o (rd_data_s)
  );

  // Loader FSM; a new download overrides everything, and an exit beats a pending copy write.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      dl_q         <= 1'b0;
      m1_q         <= 1'b1;
      is_p_q       <= 1'b0;
      tape_ready_q <= 1'b0;
      overflow_q   <= 1'b0;
      active_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= 16'h0000;
      ram_data_q   <= 8'h00;
      tape_len_q   <= {(TAPE_AW+1){1'b0}};
      rd_ptr_q     <= {(TAPE_AW+1){1'b0}};
    end else begin
      dl_q     <= ioctl_download;
      m1_q     <= nM1;
      ram_we_q <= 1'b0;
      if (dl_start_s) begin
        state_q      <= ST_LOADING;
        tape_ready_q <= 1'b0;
        overflow_q   <= 1'b0;
        tape_len_q   <= {(TAPE_AW+1){1'b0}};
        is_p_q       <= |ioctl_index[7:6];
        active_q     <= 1'b0;
      end else begin
        case (state_q)
          ST_LOADING: begin
            if (ioctl_wr) begin
              if (in_range_s) begin
                tape_len_q <= {1'b0, ioctl_addr[TAPE_AW-1:0]} + {{TAPE_AW{1'b0}}, 1'b1};
              end else begin
                overflow_q <= 1'b1;
              end
            end
            if (dl_end_s) begin
              if ((tape_len_q == {(TAPE_AW+1){1'b0}}) && !(ioctl_wr && in_range_s)) begin
                state_q <= ST_EMPTY;
              end else begin
                state_q      <= ST_READY;
                tape_ready_q <= 1'b1;
              end
            end
          end
          ST_READY: begin
            if (trap_hit_s) begin
              state_q  <= ST_COPY;
              rd_ptr_q <= {(TAPE_AW+1){1'b0}};
              active_q <= 1'b1;
            end
          end
          ST_COPY: begin
            if (exit_hit_s) begin
              state_q  <= ST_READY;
              active_q <= 1'b0;
            end else if (ce_cpu_p) begin
              if (rd_ptr_q < tape_len_q) begin
                ram_we_q   <= 1'b1;
                ram_addr_q <= base_s + 16'(rd_ptr_q);
                ram_data_q <= rd_data_s;
                rd_ptr_q   <= rd_ptr_q + {{TAPE_AW{1'b0}}, 1'b1};
              end else begin
                state_q <= ST_DONE;
              end
            end
          end
          ST_DONE: begin
            if (trap_hit_s) begin
              state_q  <= ST_COPY;
              rd_ptr_q <= {(TAPE_AW+1){1'b0}};
              active_q <= 1'b1;
            end else if (exit_hit_s) begin
              state_q  <= ST_READY;
              active_q <= 1'b0;
            end
          end
          ST_EMPTY: begin
            state_q <= ST_EMPTY;
          end
          default: begin
            state_q  <= ST_EMPTY;
            active_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Opcode overlay stays combinational so the CPU fetch path sees no extra latency.
  always_comb begin
    patch_dout = 8'hFF;
    if ((state_q == ST_COPY) || (state_q == ST_DONE)) begin
      patch_dout = patch_byte(cpu_addr - trap_addr_s, state_q == ST_DONE, zx81);
    end else begin
      patch_dout = 8'hFF;
    end
  end

  assign active     = active_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_data   = ram_data_q;
  assign tape_ready = tape_ready_q;
  assign overflow   = overflow_q;
  assign tape_len   = tape_len_q;

endmodule

// File: tb/tb_zx8x_fastload.sv
// Directed bench for zx8x_fastload with a RAM-write scoreboard (TAPE_AW=4, depth 16).
module tb_zx8x_fastload;

  localparam int AW = 4;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          ce_cpu_p = 1'b0;
  logic          zx81 = 1'b1;
  logic          ioctl_download = 1'b0;
  logic [7:0]    ioctl_index = 8'h00;
  logic          ioctl_wr = 1'b0;
  logic [24:0]   ioctl_addr = 25'd0;
  logic [7:0]    ioctl_dout = 8'h00;
  logic [15:0]   cpu_addr = 16'h0000;
  logic          nM1 = 1'b1;
  logic          active;
  logic [7:0]    patch_dout;
  logic          ram_we;
  logic [15:0]   ram_addr;
  logic [7:0]    ram_data;
  logic          tape_ready;
  logic          overflow;
  logic [AW:0]   tape_len;

  int total = 0;
  int bad = 0;
  logic [23:0] exp_q [$];
  logic [7:0]  dl_bytes [0:31];

  zx8x_fastload #(.TAPE_AW(AW), .O_BASE(16'h4000), .P_BASE(16'h4009)) u_dut (
    .clk_sys(clk_sys), .reset(reset), .ce_cpu_p(ce_cpu_p), .zx81(zx81),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .cpu_addr(cpu_addr), .nM1(nM1),
    .active(active), .patch_dout(patch_dout), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_data(ram_data), .tape_ready(tape_ready), .overflow(overflow), .tape_len(tape_len)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Monitor: every RAM write strobe must match the oldest expected write.
  always @(negedge clk_sys) begin
    if (ram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ram_we", {8'h00, ram_addr, ram_data}, 32'hFFFFFFFF);
      end else begin
        chk("ram_write", {8'h00, ram_addr, ram_data}, {8'h00, exp_q.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic expect_wr(input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic ce_pulse(input int n);
    for (int k = 0; k < n; k++) begin
      ce_cpu_p = 1'b1;
      tick(1);
      ce_cpu_p = 1'b0;
      tick(3);
    end
  endtask

  task automatic m1_fetch(input logic [15:0] a);
    cpu_addr = a;
    nM1 = 1'b0;
    tick(3);
    nM1 = 1'b1;
    tick(1);
  endtask

  task automatic write_bytes(input int n);
    for (int k = 0; k < n; k++) begin
      ioctl_addr = 25'(k);
      ioctl_dout = dl_bytes[k];
      ioctl_wr = 1'b1;
      tick(1);
      ioctl_wr = 1'b0;
      tick(1);
    end
  endtask

  task automatic download(input logic [7:0] idx, input int n);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    tick(2);
    write_bytes(n);
    ioctl_download = 1'b0;
    tick(2);
  endtask

  task automatic chk_reset_outputs(input string tag);
    @(negedge clk_sys);
    chk({tag, "_active"}, {31'd0, active}, 32'd0);
    chk({tag, "_patch"}, {24'd0, patch_dout}, 32'h000000FF);
    chk({tag, "_ram_we"}, {31'd0, ram_we}, 32'd0);
    chk({tag, "_ram_addr"}, {16'd0, ram_addr}, 32'd0);
    chk({tag, "_ram_data"}, {24'd0, ram_data}, 32'd0);
    chk({tag, "_tape_ready"}, {31'd0, tape_ready}, 32'd0);
    chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    chk({tag, "_tape_len"}, {27'd0, tape_len}, 32'd0);
  endtask

  task automatic chk_patch(input string name, input logic [15:0] a, input logic [7:0] want);
    cpu_addr = a;
    #1;
    chk(name, {24'd0, patch_dout}, {24'd0, want});
  endtask

  initial begin
    tick(3);
    chk_reset_outputs("reset");
    reset = 1'b0;
    tick(2);

    // ZX81 .p image of three bytes
    zx81 = 1'b1;
    dl_bytes[0] = 8'h11; dl_bytes[1] = 8'h22; dl_bytes[2] = 8'h33;
    download(8'h41, 3);
    chk("p_ready", {31'd0, tape_ready}, 32'd1);
    chk("p_len", {27'd0, tape_len}, 32'd3);
    chk("p_ovf", {31'd0, overflow}, 32'd0);
    m1_fetch(16'h0347);
    chk("p_active", {31'd0, active}, 32'd1);
    chk_patch("p_patch_0347", 16'h0347, 8'hAF);
    chk_patch("p_patch_0348_copy", 16'h0348, 8'h00);
    chk_patch("p_patch_034C", 16'h034C, 8'h07);
    expect_wr(16'h4009, 8'h11);
    expect_wr(16'h400A, 8'h22);
    expect_wr(16'h400B, 8'h33);
    ce_pulse(5);
    chk_patch("p_patch_0348_done", 16'h0348, 8'h37);
    chk_patch("p_patch_034E", 16'h034E, 8'hFF);
    chk("p_done_active", {31'd0, active}, 32'd1);
    m1_fetch(16'h0500);
    chk("exit_active", {31'd0, active}, 32'd0);
    chk_patch("exit_patch", 16'h0348, 8'hFF);

    // Exit during COPY, then restart from the first byte
    m1_fetch(16'h0347);
    expect_wr(16'h4009, 8'h11);
    ce_pulse(1);
    m1_fetch(16'h0500);
    chk("copy_exit_active", {31'd0, active}, 32'd0);
    ce_pulse(2);
    m1_fetch(16'h0347);
    expect_wr(16'h4009, 8'h11);
    expect_wr(16'h400A, 8'h22);
    ce_pulse(2);

    // New .o download aborts the running copy
    zx81 = 1'b0;
    ioctl_index = 8'h01;
    ioctl_download = 1'b1;
    tick(2);
    chk("abort_ready", {31'd0, tape_ready}, 32'd0);
    chk("abort_active", {31'd0, active}, 32'd0);
    ce_pulse(2);
    dl_bytes[0] = 8'hAA; dl_bytes[1] = 8'hBB;
    write_bytes(2);
    ioctl_download = 1'b0;
    tick(2);
    chk("o_len", {27'd0, tape_len}, 32'd2);
    chk("o_ready", {31'd0, tape_ready}, 32'd1);
    m1_fetch(16'h0207);
    chk("o_active", {31'd0, active}, 32'd1);
    chk_patch("o_patch_020C", 16'h020C, 8'h03);
    expect_wr(16'h4000, 8'hAA);
    expect_wr(16'h4001, 8'hBB);
    ce_pulse(3);
    chk_patch("o_patch_0208_done", 16'h0208, 8'h37);
    m1_fetch(16'h0100);
    chk("o_exit_low", {31'd0, active}, 32'd0);

    // Reset in the middle of a copy
    m1_fetch(16'h0207);
    expect_wr(16'h4000, 8'hAA);
    ce_pulse(1);
    reset = 1'b1;
    tick(1);
    chk_reset_outputs("midcopy_reset");
    reset = 1'b0;
    tick(1);
    zx81 = 1'b1;
    m1_fetch(16'h0347);
    chk("post_reset_trap", {31'd0, active}, 32'd0);
    ce_pulse(2);

    // Index 0 downloads are ignored
    dl_bytes[0] = 8'h55;
    download(8'h00, 1);
    chk("idx0_ready", {31'd0, tape_ready}, 32'd0);
    chk("idx0_len", {27'd0, tape_len}, 32'd0);

    // Overflow: 20 bytes into a 16-byte buffer
    zx81 = 1'b0;
    for (int k = 0; k < 20; k++) dl_bytes[k] = 8'h80 + 8'(k);
    download(8'h01, 20);
    chk("ovf_len", {27'd0, tape_len}, 32'd16);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_ready", {31'd0, tape_ready}, 32'd1);
    m1_fetch(16'h0207);
    for (int k = 0; k < 16; k++) expect_wr(16'h4000 + 16'(k), 8'h80 + 8'(k));
    ce_pulse(18);
    chk_patch("ovf_done_patch", 16'h0208, 8'h37);

    tick(4);
    chk("pending_writes", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zx8x_fastload.md
# zx8x_fastload

Parametrised instant tape loader for the ZX80/ZX81 core. It captures a .o or .p image from the HPS download channel into a private buffer. When the CPU enters the ROM LOAD routine, it overlays a 7-byte patch loop on the opcode stream and streams the image into system RAM, one byte per CPU clock enable. It sits between hps_io, the T80 bus decode and the main RAM write port, and replaces the inline tape logic of the top level.

## Interface
Parameters:
- TAPE_AW, 14: buffer address width; depth = 2^TAPE_AW bytes.
- O_BASE, 16'h4000: RAM destination for .o (ZX80) images.
- P_BASE, 16'h4009: RAM destination for .p (ZX81) images.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high.
- ce_cpu_p  in  1  CPU positive clock enable.
- zx81  in  1  model: 1 = ZX81 traps, 0 = ZX80 traps.
- ioctl_download  in  1  download in progress.
- ioctl_index  in  8  download index; 0 = ROM/other (ignored), [7:6]≠0 selects .p, otherwise .o.
- ioctl_wr  in  1  download byte strobe.
- ioctl_addr  in  25  download byte address.
- ioctl_dout  in  8  download byte.
- cpu_addr  in  16  CPU address bus.
- nM1  in  1  CPU M1, active low.
- active  out  1  patch overlay enabled; top level muxes patch_dout onto mem_out.
- patch_dout  out  8  patch byte for cpu_addr.
- ram_we  out  1  RAM write strobe (single clk_sys pulse).
- ram_addr  out  16  RAM write address.
- ram_data  out  8  RAM write data.
- tape_ready  out  1  valid image held.
- overflow  out  1  last image exceeded buffer depth.
- tape_len  out  TAPE_AW+1  captured image length in bytes.

## Operation
- States: EMPTY, LOADING, READY, COPY, DONE.
- EMPTY/any state + rising ioctl_download with index≠0 → LOADING.
  - Clear tape_ready, overflow, tape_len.
  - Latch is_p = |index[7:6].
- LOADING, per ioctl_wr:
  - addr < depth: write buffer, tape_len <= addr+1.
  - addr ≥ depth: discard byte, set overflow.
- Falling ioctl_download → READY, tape_ready=1; a zero-length image → EMPTY.
- Downloads with index 0 are ignored in every state.
- Trap detection on each nM1 falling edge (registered edge detect), only when tape_ready:
  - trap = zx81 ? 16'h0347 : 16'h0207; end = zx81 ? 16'h03C3 : 16'h024D.
  - cpu_addr==trap in READY or DONE → COPY, rd_ptr=0, active=1.
  - cpu_addr ≥ end or < trap in COPY/DONE → READY, active=0.
- Patch ROM, indexed by i = cpu_addr − trap:
  - Bytes: AF, S, 30, FD, C3, L, 02, where L = zx81 ? 07 : 03.
  - S = 00 (NOP) in COPY, 37 (SCF) in DONE.
  - i > 6 → FF.
- COPY, per ce_cpu_p:
  - rd_ptr < tape_len: ram_we pulse, ram_addr = (is_p ? P_BASE : O_BASE) + rd_ptr (16-bit wrap), ram_data = buf[rd_ptr], rd_ptr++.
  - rd_ptr == tape_len: → DONE.
- Image is retained after an exit, so a repeated LOAD re-copies it.

## Timing
- Reset values: active=0, patch_dout=FF, ram_we=0, ram_addr=0, ram_data=0, tape_ready=0, overflow=0, tape_len=0, state EMPTY. Buffer contents are not cleared.
- Buffer read is registered from rd_ptr. Data is valid by every ce_cpu_p, because ce_cpu_p is no more often than 1 in 2 clocks.
- ram_we is registered: high exactly one clk_sys cycle after a qualifying ce_cpu_p. ram_addr/ram_data are stable in that cycle.
- N bytes take N ce_cpu_p periods. DONE is entered on the (N+1)th ce_cpu_p.
- patch_dout is combinational from cpu_addr and state; there is zero added latency on the opcode path.
- Simultaneous events:
  - Exit condition and COPY write on the same ce cycle: exit wins, no ram_we.
  - Download start during COPY: abort immediately, active=0, no further writes.
  - Trap and exit on the same M1 cannot coincide, since trap lies inside the window.
  - Reset mid-COPY: all outputs return to reset values on the next edge.

## Structure
- Package zx8x_pkg holds:
  - the state enum;
  - trap/end constants for both models;
  - the 7-byte patch template;
  - the loop-target low bytes.
- Sub-module zx8x_tape_buf: simple dual-port RAM (write from ioctl, registered read), parametrised by TAPE_AW.

## Test plan
- Load a 3-byte .p image (index 8'h41: 11,22,33) with zx81=1. Fetch M1 at 0347h, then run 5 ce → ram writes 4009:11, 400A:22, 400B:33. patch_dout at 0348h = 00, then 37 after the third write.
- zx81=0, load a 2-byte .o image (index 8'h01) → trap at 0207h. Writes go to 4000/4001, and patch at 020Ch = 03.
- TAPE_AW=4, load 20 bytes → tape_len=16, overflow=1. COPY writes exactly 16 bytes.
- During COPY, M1 fetch at 0500h → active=0 on the next cycle, no further ram_we. A second M1 at 0347h restarts from rd_ptr 0.
- Assert a new download (index 1) mid-COPY → tape_ready=0, active=0, writes stop.
- Assert reset mid-COPY → all outputs reset. A subsequent M1 at 0347h is ignored (tape_ready=0).
